// File: rtl/tone_if.sv
// tone_if: tone input and detected-note outputs between source (master) and detector (slave)
interface tone_if;
  logic tone_in;
  logic [2:0] num_show;
  logic note_valid;
  logic note_change;
  logic [12:0] period_out;
  modport master(output tone_in, input num_show, note_valid, note_change, period_out);
  modport slave(input tone_in, output num_show, note_valid, note_change, period_out);
endinterface

// File: rtl/tone_detector.sv
// tone_detector: measures square-wave period and confirms scale note do..xi after MATCH_CNT agreeing periods
module tone_detector #(
  parameter int MATCH_CNT = 3,
  parameter int TIMEOUT = 8191
) (
  input logic clk,
  input logic rst,
  tone_if.slave bus
);
  localparam logic [12:0] TO = 13'(TIMEOUT);
  localparam logic [2:0] MC = 3'(MATCH_CNT);
  typedef enum logic {IDLE, MEASURE} state_t;
  state_t state;
  logic [2:0] sync;
  logic [12:0] cnt;
  logic [2:0] cand, match, cls, nxt_match;
  logic rise;
  assign rise = sync[1] & ~sync[2];
  // band edges sit midway between neighbouring nominal periods
  always_comb begin
    cls = (cnt > 13'd4000 || cnt < 13'd1900) ? 3'd0 :
          cnt >= 13'd3609 ? 3'd1 :
          cnt >= 13'd3216 ? 3'd2 :
          cnt >= 13'd2948 ? 3'd3 :
          cnt >= 13'd2709 ? 3'd4 :
          cnt >= 13'd2412 ? 3'd5 :
          cnt >= 13'd2148 ? 3'd6 : 3'd7;
    nxt_match = (cls == cand) ? (match >= MC ? MC : match + 3'd1) : 3'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sync <= '0;
      cnt <= '0;
      cand <= '0;
      match <= '0;
      bus.num_show <= '0;
      bus.note_valid <= 1'b0;
      bus.note_change <= 1'b0;
      bus.period_out <= '0;
    end else begin
      sync <= {sync[1:0], bus.tone_in};
      bus.note_change <= 1'b0;
      if (state == IDLE) begin
        if (rise) begin
          state <= MEASURE;
          cnt <= 13'd1;
        end
      end else if (rise) begin
        cnt <= 13'd1;
        bus.period_out <= cnt;
        if (cls == 3'd0) begin
          cand <= '0;
          match <= '0;
          bus.num_show <= '0;
          bus.note_valid <= 1'b0;
        end else begin
          cand <= cls;
          match <= nxt_match;
          if (nxt_match == MC) begin
            bus.num_show <= cls;
            bus.note_valid <= 1'b1;
            bus.note_change <= !bus.note_valid || bus.num_show != cls;
          end
        end
      end else if (cnt >= TO) begin
        state <= IDLE;
        cand <= '0;
        match <= '0;
        bus.num_show <= '0;
        bus.note_valid <= 1'b0;
      end else begin
        cnt <= cnt + 13'd1;
      end
    end
  end
endmodule

// File: tb/tb_tone_detector.sv
// tb_tone_detector: directed tone sequences on a MATCH_CNT=3 unit and a MATCH_CNT=1 unit sharing one input
module tb_tone_detector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tone = 1'b0;
  int total = 0;
  int bad = 0;
  int pulses = 0;
  int bp[6] = '{3608, 3609, 1899, 1900, 4000, 4001};
  int bc[6] = '{2, 1, 0, 7, 1, 0};
  always #5 clk = ~clk;
  tone_if t1();
  tone_if t2();
  assign t1.tone_in = tone;
  assign t2.tone_in = tone;
  tone_detector #(.MATCH_CNT(3), .TIMEOUT(8191)) dut (.clk(clk), .rst(rst), .bus(t1));
  tone_detector #(.MATCH_CNT(1), .TIMEOUT(8191)) dut1 (.clk(clk), .rst(rst), .bus(t2));
  always @(negedge clk) if (t1.note_change) pulses++;
  task automatic chk(string tag, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic per(int hi, int lo);
    tone = 1'b1;
    cyc(hi);
    tone = 1'b0;
    cyc(lo);
  endtask
  task automatic outs(string tag, int ns, int nv, int po);
    chk({tag, ".num"}, int'(t1.num_show), ns);
    chk({tag, ".valid"}, int'(t1.note_valid), nv);
    chk({tag, ".period"}, int'(t1.period_out), po);
  endtask
  initial begin
    @(negedge clk);
    tone = 1'b1;
    cyc(1);
    tone = 1'b0;
    cyc(1);
    rst = 1'b0;
    outs("rst", 0, 0, 0);
    chk("rst.chg", int'(t1.note_change), 0);
    cyc(100);
    outs("idle", 0, 0, 0);
    chk("idle.pulses", pulses, 0);
    per(1136, 1136);
    outs("la.arm", 0, 0, 0);
    per(1136, 1136);
    outs("la.p1", 0, 0, 2272);
    per(1136, 1136);
    outs("la.p2", 0, 0, 2272);
    per(1136, 1136);
    outs("la.p3", 6, 1, 2272);
    chk("la.pulse", pulses, 1);
    per(1136, 1136);
    outs("la.p4", 6, 1, 2272);
    chk("la.nopulse", pulses, 1);
    per(1908, 1908);
    outs("do.d0", 6, 1, 2272);
    per(1908, 1908);
    outs("do.d1", 6, 1, 3816);
    per(1908, 1908);
    outs("do.d2", 6, 1, 3816);
    per(1908, 1908);
    outs("do.d3", 1, 1, 3816);
    chk("do.pulse", pulses, 2);
    per(750, 750);
    outs("oob.pre", 1, 1, 3816);
    per(1136, 1136);
    outs("oob", 0, 0, 1500);
    per(1136, 1136);
    outs("oob.l1", 0, 0, 2272);
    per(1136, 1136);
    outs("oob.l2", 0, 0, 2272);
    per(1136, 1136);
    outs("oob.l3", 6, 1, 2272);
    chk("oob.pulse", pulses, 3);
    tone = 1'b1;
    cyc(3 + 8191 - 1);
    outs("to.pre", 6, 1, 2272);
    cyc(1);
    outs("to", 0, 0, 2272);
    cyc(9000 - 3 - 8191);
    tone = 1'b0;
    cyc(1136);
    chk("to.pulse", pulses, 3);
    per(1136, 1136);
    outs("re.arm", 0, 0, 2272);
    per(1136, 1136);
    outs("re.p1", 0, 0, 2272);
    per(1136, 1136);
    outs("re.p2", 0, 0, 2272);
    per(1136, 1136);
    outs("re.p3", 6, 1, 2272);
    chk("re.pulse", pulses, 4);
    for (int i = 0; i < 6; i++) begin
      per(bp[i] / 2, bp[i] - bp[i] / 2);
      if (i > 0) begin
        chk($sformatf("bnd%0d.num", bp[i-1]), int'(t2.num_show), bc[i-1]);
        chk($sformatf("bnd%0d.period", bp[i-1]), int'(t2.period_out), bp[i-1]);
        chk($sformatf("bnd%0d.valid", bp[i-1]), int'(t2.note_valid), int'(bc[i-1] != 0));
      end
    end
    tone = 1'b1;
    cyc(10);
    chk("bnd4001.num", int'(t2.num_show), 0);
    chk("bnd4001.period", int'(t2.period_out), 4001);
    outs("bnd4001.m3", 0, 0, 4001);
    cyc(490);
    rst = 1'b1;
    tone = 1'b0;
    cyc(1);
    rst = 1'b0;
    outs("mrst", 0, 0, 0);
    chk("mrst.p2", int'(t2.period_out), 0);
    cyc(10);
    per(1136, 1136);
    outs("mrst.arm", 0, 0, 0);
    per(1136, 1136);
    outs("mrst.p1", 0, 0, 2272);
    chk("mrst.m1num", int'(t2.num_show), 6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
